// File: rtl/output_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : output_arbiter
//  Description : Two-requester round-robin arbiter feeding a small FIFO whose
//                head word is offered downstream over a valid/ready handshake.
//                Requester 0 is the writeback path, requester 1 debug/trace.
//  Revision    : 1.0 - initial release
// ============================================================================
module output_arbiter #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req0_valid,
  input  logic signed [WIDTH-1:0]   req0_data,
  output logic                      req0_ready,
  input  logic                      req1_valid,
  input  logic signed [WIDTH-1:0]   req1_data,
  output logic                      req1_ready,
  output logic                      y_valid,
  output logic signed [WIDTH-1:0]   y,
  input  logic                      y_ready,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

  // Storage and bookkeeping state
  logic signed [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]           r_wr_ptr;
  logic [AW-1:0]           r_rd_ptr;
  logic [CW-1:0]           r_count;
  logic                    r_last_grant;

  // Combinational decode
  logic                    w_full;
  logic                    w_empty;
  logic                    w_grant0;
  logic                    w_grant1;
  logic                    w_push0;
  logic                    w_push1;
  logic                    w_push;
  logic                    w_pop;
  logic signed [WIDTH-1:0] w_push_data;

  // Arbitration and handshake decode; ready depends only on registered state
  // and the requesters' valids, never on y_ready.
  always_comb begin
    w_full      = (r_count == C_DEPTH);
    w_empty     = (r_count == '0);
    // Under contention the requester that did not win last time is granted.
    w_grant0    = req0_valid && (!req1_valid || r_last_grant);
    w_grant1    = req1_valid && (!req0_valid || !r_last_grant);
    req0_ready  = w_grant0 && !w_full;
    req1_ready  = w_grant1 && !w_full;
    w_push0     = req0_valid && req0_ready;
    w_push1     = req1_valid && req1_ready;
    w_push      = w_push0 || w_push1;
    w_push_data = w_push1 ? req1_data : req0_data;
    w_pop       = !w_empty && y_ready;
  end

  // Head-of-FIFO presentation; the output is forced to zero when empty.
  always_comb begin
    y_valid = !w_empty;
    y       = w_empty ? '0 : r_mem[r_rd_ptr];
    count   = r_count;
  end

  // Pointer, occupancy and fairness state; a stalled grant leaves last_grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_last_grant <= 1'b1;
    end else begin
      if (w_push) begin
        r_wr_ptr     <= r_wr_ptr + AW'(1);
        r_last_grant <= w_push1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_push_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_output_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_output_arbiter
//  Description : Self-checking bench for output_arbiter; a queue-based model
//                of arbitration and FIFO order predicts every output.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_output_arbiter;

  localparam int DEPTH = 4;
  localparam int WIDTH = 32;
  localparam int CW    = 3;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    req0_valid;
  logic signed [WIDTH-1:0] req0_data;
  logic                    req0_ready;
  logic                    req1_valid;
  logic signed [WIDTH-1:0] req1_data;
  logic                    req1_ready;
  logic                    y_valid;
  logic signed [WIDTH-1:0] y;
  logic                    y_ready;
  logic [CW-1:0]           count;

  int checks   = 0;
  int failures = 0;

  // Reference model: a queue of accepted words plus the last winner.
  logic signed [WIDTH-1:0] mq[$];
  bit                      m_last = 1'b1;
  bit                      m_push0 = 1'b0;
  bit                      m_push1 = 1'b0;

  // Free-running clock
  always #5 clk = ~clk;

  output_arbiter #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .y_valid    (y_valid),
    .y          (y),
    .y_ready    (y_ready),
    .count      (count)
  );

  function automatic int m_grant();
    if (req0_valid && req1_valid) return m_last ? 0 : 1;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  function automatic bit m_ready0();
    return (m_grant() == 0) && (mq.size() < DEPTH);
  endfunction

  function automatic bit m_ready1();
    return (m_grant() == 1) && (mq.size() < DEPTH);
  endfunction

  function automatic logic signed [WIDTH-1:0] m_y();
    if (mq.size() != 0) return mq[0];
    return '0;
  endfunction

  task automatic set_in(input bit v0, input logic signed [WIDTH-1:0] d0,
                        input bit v1, input logic signed [WIDTH-1:0] d1,
                        input bit yr);
    req0_valid = v0; req0_data = d0;
    req1_valid = v1; req1_data = d1;
    y_ready    = yr;
  endtask

  // Moves the model across the coming edge using the driven inputs, then
  // waits for that edge.
  task automatic advance();
    int g;
    bit full;
    logic signed [WIDTH-1:0] tmp;
    g = m_grant();
    full = (mq.size() == DEPTH);
    m_push0 = 1'b0;
    m_push1 = 1'b0;
    if (rst) begin
      mq.delete();
      m_last = 1'b1;
    end else begin
      if (mq.size() != 0 && y_ready) tmp = mq.pop_front();
      if (g >= 0 && !full) begin
        if (g == 0) begin mq.push_back(req0_data); m_push0 = 1'b1; end
        else        begin mq.push_back(req1_data); m_push1 = 1'b1; end
        m_last = (g == 1);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_in(1'b1, -32'sd5, 1'b1, 32'sd77, 1'b0);
    advance();
    @(negedge clk);
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d want=0", count); end
    checks++; if (y_valid !== 1'b0) begin failures++; $display("FAIL reset_y_valid got=%b want=0", y_valid); end
    checks++; if (y !== 32'sd0) begin failures++; $display("FAIL reset_y got=%0d want=0", y); end
    advance();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin failures++; $display("FAIL reset_first_grant got=%b%b want=10", req0_ready, req1_ready); end
    advance();
    set_in(1'b0, 0, 1'b0, 0, 1'b1);
    @(negedge clk);
    checks++; if (y_valid !== 1'b1 || y !== -32'sd5) begin failures++; $display("FAIL reset_first_word got=%b/%0d want=1/-5", y_valid, y); end
    advance();
  endtask

  task automatic test_round_robin();
    logic signed [WIDTH-1:0] d0s[3] = '{32'sd1, 32'sd2, 32'sd3};
    logic signed [WIDTH-1:0] d1s[3] = '{32'sd100, 32'sd200, 32'sd300};
    logic signed [WIDTH-1:0] exp[6] = '{32'sd1, 32'sd100, 32'sd2, 32'sd200, 32'sd3, 32'sd300};
    logic signed [WIDTH-1:0] a, b;
    int i0 = 0, i1 = 0, nout = 0, first = -1, last = -1;
    rst = 1'b1; set_in(1'b0, 0, 1'b0, 0, 1'b0); advance(); rst = 1'b0;
    for (int cyc = 0; cyc < 20 && nout < 6; cyc++) begin
      a = 0; b = 0;
      if (i0 < 3) a = d0s[i0];
      if (i1 < 3) b = d1s[i1];
      set_in(i0 < 3, a, i1 < 3, b, 1'b1);
      @(negedge clk);
      checks++; if (req0_ready !== m_ready0() || req1_ready !== m_ready1()) begin failures++; $display("FAIL rr_ready cyc=%0d got=%b%b want=%b%b", cyc, req0_ready, req1_ready, m_ready0(), m_ready1()); end
      if (mq.size() != 0) begin
        checks++; if (y_valid !== 1'b1 || y !== exp[nout]) begin failures++; $display("FAIL rr_order idx=%0d got=%b/%0d want=1/%0d", nout, y_valid, y, exp[nout]); end
        if (first < 0) first = cyc;
        last = cyc;
        nout++;
      end
      advance();
      if (m_push0) i0++;
      if (m_push1) i1++;
    end
    checks++; if (nout !== 6 || last - first !== 5) begin failures++; $display("FAIL rr_rate got words=%0d span=%0d want words=6 span=5", nout, last - first); end
  endtask

  task automatic test_fill_full();
    logic signed [WIDTH-1:0] fill[4] = '{32'sd10, 32'sd20, 32'sd30, 32'sd40};
    logic signed [WIDTH-1:0] exp[5] = '{32'sd20, 32'sd30, 32'sd40, 32'sd50, 32'sd60};
    int k = 0;
    bit p1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_in(1'b0, 0, 1'b1, fill[i], 1'b0);
      advance();
    end
    set_in(1'b1, 32'sd50, 1'b1, 32'sd60, 1'b0);
    @(negedge clk);
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL full_count got=%0d want=4", count); end
    checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%b%b want=00", req0_ready, req1_ready); end
    advance();
    set_in(1'b1, 32'sd50, 1'b1, 32'sd60, 1'b1);
    @(negedge clk);
    checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || y !== 32'sd10) begin failures++; $display("FAIL full_pop_no_push got=%b%b/%0d want=00/10", req0_ready, req1_ready, y); end
    advance();
    set_in(1'b1, 32'sd50, 1'b1, 32'sd60, 1'b0);
    @(negedge clk);
    checks++; if (count !== 3'd3 || req0_ready !== 1'b1 || req1_ready !== 1'b0) begin failures++; $display("FAIL full_after_pop got=%0d/%b%b want=3/10", count, req0_ready, req1_ready); end
    advance();
    for (int cyc = 0; cyc < 20 && k < 5; cyc++) begin
      set_in(1'b0, 0, !p1, 32'sd60, 1'b1);
      @(negedge clk);
      checks++; if (req1_ready !== m_ready1() || count !== CW'(mq.size())) begin failures++; $display("FAIL drain_state got=%b/%0d want=%b/%0d", req1_ready, count, m_ready1(), mq.size()); end
      if (mq.size() != 0) begin
        checks++; if (y !== exp[k]) begin failures++; $display("FAIL drain_order idx=%0d got=%0d want=%0d", k, y, exp[k]); end
        k++;
      end
      advance();
      if (m_push1) p1 = 1'b1;
    end
    checks++; if (k !== 5) begin failures++; $display("FAIL drain_total got=%0d want=5", k); end
  endtask

  task automatic test_wrap();
    logic signed [WIDTH-1:0] words[10] = '{32'sh7FFFFFFF, 32'sh80000000, 32'sd0, 32'sd1,
                                           32'sd2, 32'sd3, 32'sd4, 32'sd5, 32'sd6, 32'sd7};
    logic signed [WIDTH-1:0] d;
    int idx = 0, k = 0;
    bit yr;
    for (int cyc = 0; cyc < 80 && (idx < 10 || mq.size() != 0); cyc++) begin
      yr = (mq.size() == DEPTH) || (idx >= 10);
      d = 0;
      if (idx < 10) d = words[idx];
      set_in(idx < 10, d, 1'b0, 0, yr);
      @(negedge clk);
      checks++; if (req0_ready !== m_ready0() || count !== CW'(mq.size())) begin failures++; $display("FAIL wrap_state cyc=%0d got=%b/%0d want=%b/%0d", cyc, req0_ready, count, m_ready0(), mq.size()); end
      if (mq.size() != 0 && yr) begin
        checks++; if (k >= 10 || y !== words[k]) begin failures++; $display("FAIL wrap_order idx=%0d got=%0d", k, y); end
        k++;
      end
      advance();
      if (m_push0) idx++;
    end
    checks++; if (k !== 10) begin failures++; $display("FAIL wrap_total got=%0d want=10", k); end
  endtask

  task automatic test_empty_idle();
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, 0, 1'b0, 0, 1'b1);
      @(negedge clk);
      checks++; if (count !== 3'd0 || y_valid !== 1'b0 || y !== 32'sd0) begin failures++; $display("FAIL idle got=%0d/%b/%0d want=0/0/0", count, y_valid, y); end
      advance();
    end
    set_in(1'b1, 32'sd42, 1'b0, 0, 1'b1);
    @(negedge clk);
    checks++; if (y_valid !== 1'b0 || req0_ready !== 1'b1) begin failures++; $display("FAIL idle_no_bypass got=%b/%b want=0/1", y_valid, req0_ready); end
    advance();
    set_in(1'b0, 0, 1'b0, 0, 1'b1);
    @(negedge clk);
    checks++; if (y_valid !== 1'b1 || y !== 32'sd42) begin failures++; $display("FAIL idle_word got=%b/%0d want=1/42", y_valid, y); end
    advance();
    @(negedge clk);
    checks++; if (y_valid !== 1'b0 || count !== 3'd0) begin failures++; $display("FAIL idle_after_pop got=%b/%0d want=0/0", y_valid, count); end
    advance();
  endtask

  task automatic test_reset_mid();
    logic signed [WIDTH-1:0] w[3] = '{32'sd111, 32'sd222, 32'sd333};
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, w[i], 1'b0, 0, 1'b0);
      advance();
    end
    set_in(1'b0, 0, 1'b0, 0, 1'b0);
    @(negedge clk);
    checks++; if (count !== 3'd3) begin failures++; $display("FAIL mid_fill got=%0d want=3", count); end
    rst = 1'b1;
    advance();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (count !== 3'd0 || y_valid !== 1'b0 || y !== 32'sd0) begin failures++; $display("FAIL mid_cleared got=%0d/%b/%0d want=0/0/0", count, y_valid, y); end
    set_in(1'b1, 32'sd555, 1'b1, 32'sd666, 1'b1);
    #1;
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin failures++; $display("FAIL mid_priority got=%b%b want=10", req0_ready, req1_ready); end
    advance();
    set_in(1'b0, 0, 1'b1, 32'sd666, 1'b1);
    @(negedge clk);
    checks++; if (y !== 32'sd555 || req1_ready !== 1'b1) begin failures++; $display("FAIL mid_first_word got=%0d/%b want=555/1", y, req1_ready); end
    advance();
    set_in(1'b0, 0, 1'b0, 0, 1'b1);
    @(negedge clk);
    checks++; if (y !== 32'sd666) begin failures++; $display("FAIL mid_second_word got=%0d want=666", y); end
    advance();
  endtask

  task automatic test_random();
    bit v0 = 1'b0, v1 = 1'b0, yr;
    logic signed [WIDTH-1:0] d0 = 0, d1 = 0;
    m_push0 = 1'b0;
    m_push1 = 1'b0;
    for (int c = 0; c < 600; c++) begin
      // A valid that was not accepted is held with the same data.
      if (!v0 || m_push0) begin v0 = ($urandom_range(0, 3) != 0); d0 = $urandom; end
      if (!v1 || m_push1) begin v1 = ($urandom_range(0, 3) != 0); d1 = $urandom; end
      rst = ($urandom_range(0, 79) == 0);
      if (((c / 100) % 2) == 0) yr = ($urandom_range(0, 3) == 0);
      else                      yr = ($urandom_range(0, 3) != 0);
      set_in(v0, d0, v1, d1, yr);
      @(negedge clk);
      checks++; if ({req0_ready, req1_ready, y_valid} !== {m_ready0(), m_ready1(), mq.size() != 0}) begin failures++; $display("FAIL rand_flags c=%0d got=%b%b%b want=%b%b%b", c, req0_ready, req1_ready, y_valid, m_ready0(), m_ready1(), mq.size() != 0); end
      checks++; if (y !== m_y() || count !== CW'(mq.size())) begin failures++; $display("FAIL rand_data c=%0d got=%0d/%0d want=%0d/%0d", c, y, count, m_y(), mq.size()); end
      advance();
    end
    rst = 1'b0;
  endtask

  // Test sequence
  initial begin
    test_reset();
    test_round_robin();
    test_fill_full();
    test_wrap();
    test_empty_idle();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Run-time bound
  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
